dmem_arbiter: RTL and testbench



---
 rtl/dmem_arbiter_if.sv | 54 +++++
 rtl/dmem_arbiter.sv | 85 ++++++++
 tb/tb_dmem_arbiter.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - signal bundle between requesters, arbiter and data memory
// Ports (signals):
//   p_*   : pipeline MEM-stage request, grant, stall and load return
//   d_*   : debug/loader request, grant and read return
//   mem_* : single-port data memory strobes, address, data
// Modports:
//   slave  : arbiter view (takes requests and mem_rdata, drives grants and mem strobes)
//   master : environment view (requesters plus memory)
interface dmem_arbiter_if #(
    parameter int DWIDTH     = 32,
    parameter int AWIDTH_MEM = 32
);
    logic                  p_req;
    logic                  p_we;
    logic [AWIDTH_MEM-1:0] p_addr;
    logic [DWIDTH-1:0]     p_wdata;
    logic                  p_gnt;
    logic                  p_stall;
    logic                  p_rvalid;
    logic [DWIDTH-1:0]     p_rdata;

    logic                  d_req;
    logic                  d_we;
    logic [AWIDTH_MEM-1:0] d_addr;
    logic [DWIDTH-1:0]     d_wdata;
    logic                  d_gnt;
    logic                  d_rvalid;
    logic [DWIDTH-1:0]     d_rdata;

    logic                  mem_ce;
    logic                  mem_wr_en;
    logic                  mem_rd_en;
    logic [AWIDTH_MEM-1:0] mem_addr;
    logic [DWIDTH-1:0]     mem_wdata;
    logic [DWIDTH-1:0]     mem_rdata;

    modport slave (
        input  p_req, p_we, p_addr, p_wdata,
        output p_gnt, p_stall, p_rvalid, p_rdata,
        input  d_req, d_we, d_addr, d_wdata,
        output d_gnt, d_rvalid, d_rdata,
        output mem_ce, mem_wr_en, mem_rd_en, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output p_req, p_we, p_addr, p_wdata,
        input  p_gnt, p_stall, p_rvalid, p_rdata,
        output d_req, d_we, d_addr, d_wdata,
        input  d_gnt, d_rvalid, d_rdata,
        input  mem_ce, mem_wr_en, mem_rd_en, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - data memory arbiter, pipeline priority with debug starvation guard
// Ports:
//   ar_clk : clock shared with the data memory
//   ar_rst : synchronous active-high reset
//   bus    : dmem_arbiter_if.slave (p/d requester ports and memory strobes)
module dmem_arbiter #(
    parameter int DWIDTH     = 32,
    parameter int AWIDTH_MEM = 32,
    parameter int MAX_WAIT   = 4
) (
    input  logic           ar_clk,
    input  logic           ar_rst,
    dmem_arbiter_if.slave  bus
);
    localparam logic [3:0] MAX_CNT = 4'(MAX_WAIT);

    logic [3:0]            wait_cnt;
    logic                  tag_p;
    logic                  tag_d;
    logic                  starve;
    logic                  d_gnt_c;
    logic                  p_gnt_c;
    logic                  wr_c;
    logic                  rd_c;
    logic [AWIDTH_MEM-1:0] addr_c;
    logic [DWIDTH-1:0]     wdata_c;

    // Grants and the memory mux are purely combinational so an access
    // completes in the cycle it is granted. With no winner every strobe and
    // field is forced to 0.
    always_comb begin
        starve  = (wait_cnt == MAX_CNT);
        d_gnt_c = bus.d_req & (~bus.p_req | starve);
        p_gnt_c = bus.p_req & ~d_gnt_c;
        wr_c    = 1'b0;
        rd_c    = 1'b0;
        addr_c  = '0;
        wdata_c = '0;
        if (d_gnt_c) begin
            wr_c    = bus.d_we;
            rd_c    = ~bus.d_we;
            addr_c  = bus.d_addr;
            wdata_c = bus.d_wdata;
        end else if (p_gnt_c) begin
            wr_c    = bus.p_we;
            rd_c    = ~bus.p_we;
            addr_c  = bus.p_addr;
            wdata_c = bus.p_wdata;
        end
    end

    // wait_cnt counts consecutive cycles d asked and lost; it clears the
    // moment d wins or stops asking, so p regains priority right after a
    // forced d win. The owner tags mark which side issued last cycle's read.
    always_ff @(posedge ar_clk) begin
        if (ar_rst) begin
            wait_cnt <= 4'd0;
            tag_p    <= 1'b0;
            tag_d    <= 1'b0;
        end else begin
            if (bus.d_req && !d_gnt_c) begin
                wait_cnt <= starve ? wait_cnt : wait_cnt + 4'd1;
            end else begin
                wait_cnt <= 4'd0;
            end
            tag_p <= p_gnt_c & ~bus.p_we;
            tag_d <= d_gnt_c & ~bus.d_we;
        end
    end

    assign bus.p_gnt     = p_gnt_c;
    assign bus.d_gnt     = d_gnt_c;
    assign bus.p_stall   = bus.p_req & ~p_gnt_c;
    assign bus.mem_ce    = p_gnt_c | d_gnt_c;
    assign bus.mem_wr_en = wr_c;
    assign bus.mem_rd_en = rd_c;
    assign bus.mem_addr  = addr_c;
    assign bus.mem_wdata = wdata_c;

    // Memory output is already registered; rvalid alone qualifies the data.
    assign bus.p_rvalid  = tag_p;
    assign bus.d_rvalid  = tag_d;
    assign bus.p_rdata   = bus.mem_rdata;
    assign bus.d_rdata   = bus.mem_rdata;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - scoreboard bench for dmem_arbiter
module tb_dmem_arbiter;
    localparam int MAX_WAIT = 4;

    logic ar_clk = 1'b0;
    logic ar_rst = 1'b1;
    always #5 ar_clk = ~ar_clk;

    dmem_arbiter_if #(.DWIDTH(32), .AWIDTH_MEM(32)) bus ();

    dmem_arbiter #(.DWIDTH(32), .AWIDTH_MEM(32), .MAX_WAIT(MAX_WAIT)) dut (
        .ar_clk (ar_clk),
        .ar_rst (ar_rst),
        .bus    (bus)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always @(posedge ar_clk) cyc <= cyc + 1;

    // Data memory: registered read, write at the edge.
    logic [31:0] mem [0:255];
    always @(posedge ar_clk) begin
        if (bus.mem_ce && bus.mem_wr_en) mem[bus.mem_addr[7:0]] <= bus.mem_wdata;
        if (bus.mem_ce && bus.mem_rd_en) bus.mem_rdata <= mem[bus.mem_addr[7:0]];
    end

    // Reference model state
    logic [31:0] ref_mem [0:255];
    int losses = 0;
    typedef struct { int due; logic [31:0] data; } rd_t;
    rd_t pq[$];
    rd_t dq[$];

    // Reference: d wins if asking and p idle, or after MAX_WAIT straight losses.
    always @(negedge ar_clk) begin
        logic ed, ep;
        logic [5:0]  exp_s, got_s;
        logic [63:0] exp_f, got_f;
        ed = bus.d_req && (!bus.p_req || losses >= MAX_WAIT);
        ep = bus.p_req && !ed;
        exp_s = {ep, ed, bus.p_req && !ep, ep || ed,
                 (ed && bus.d_we) || (ep && bus.p_we),
                 (ed && !bus.d_we) || (ep && !bus.p_we)};
        exp_f = ed ? {bus.d_addr, bus.d_wdata} : ep ? {bus.p_addr, bus.p_wdata} : 64'd0;
        got_s = {bus.p_gnt, bus.d_gnt, bus.p_stall, bus.mem_ce, bus.mem_wr_en, bus.mem_rd_en};
        got_f = {bus.mem_addr, bus.mem_wdata};
        checks++;
        if (got_s !== exp_s || got_f !== exp_f) begin
            failures++;
            $display("FAIL strobes cyc=%0d got gnt/stall/ce/we/re=%b addr_wdata=%h want %b %h",
                     cyc, got_s, got_f, exp_s, exp_f);
        end
        // Reads return the memory contents as of the grant cycle.
        if (!ar_rst) begin
            if (ed && !bus.d_we) dq.push_back('{cyc + 1, ref_mem[bus.d_addr[7:0]]});
            if (ep && !bus.p_we) pq.push_back('{cyc + 1, ref_mem[bus.p_addr[7:0]]});
        end
        if (ed && bus.d_we) ref_mem[bus.d_addr[7:0]] = bus.d_wdata;
        if (ep && bus.p_we) ref_mem[bus.p_addr[7:0]] = bus.p_wdata;
        if (ar_rst) losses = 0;
        else if (bus.d_req && !ed) losses = (losses < MAX_WAIT) ? losses + 1 : MAX_WAIT;
        else losses = 0;
    end

    // Monitor: rvalid must appear exactly when a queued read falls due.
    always @(negedge ar_clk) begin
        logic ev;
        rd_t  e;
        ev = (pq.size() > 0) && (pq[0].due == cyc);
        checks++;
        if (bus.p_rvalid !== ev) begin
            failures++;
            $display("FAIL p_rvalid cyc=%0d got %b want %b", cyc, bus.p_rvalid, ev);
        end
        if (ev) begin
            e = pq.pop_front();
            checks++;
            if (bus.p_rdata !== e.data) begin
                failures++;
                $display("FAIL p_rdata cyc=%0d got %h want %h", cyc, bus.p_rdata, e.data);
            end
        end
        ev = (dq.size() > 0) && (dq[0].due == cyc);
        checks++;
        if (bus.d_rvalid !== ev) begin
            failures++;
            $display("FAIL d_rvalid cyc=%0d got %b want %b", cyc, bus.d_rvalid, ev);
        end
        if (ev) begin
            e = dq.pop_front();
            checks++;
            if (bus.d_rdata !== e.data) begin
                failures++;
                $display("FAIL d_rdata cyc=%0d got %h want %h", cyc, bus.d_rdata, e.data);
            end
        end
    end

    task automatic tick();
        @(posedge ar_clk);
        #1;
    endtask

    task automatic set_p(input logic req, input logic we, input logic [31:0] a, input logic [31:0] w);
        bus.p_req = req; bus.p_we = we; bus.p_addr = a; bus.p_wdata = w;
    endtask

    task automatic set_d(input logic req, input logic we, input logic [31:0] a, input logic [31:0] w);
        bus.d_req = req; bus.d_we = we; bus.d_addr = a; bus.d_wdata = w;
    endtask

    initial begin
        int dcount;
        int n;
        logic pg, dg;
        for (int i = 0; i < 256; i++) begin
            mem[i]     = 32'h1000 + i;
            ref_mem[i] = 32'h1000 + i;
        end
        mem[3]     = 32'h12;
        ref_mem[3] = 32'h12;
        set_p(0, 0, 0, 0);
        set_d(0, 0, 0, 0);
        ar_rst = 1'b1;
        tick(); tick();
        ar_rst = 1'b0;
        tick();

        // Pipeline store then load of addr 5
        set_p(1, 1, 5, 32'hDEADBEEF); tick();
        set_p(1, 0, 5, 0);            tick();
        set_p(0, 0, 0, 0);            tick(); tick();

        // Continuous contention: d must win one cycle in every MAX_WAIT+1
        set_p(1, 0, 1, 0);
        set_d(1, 0, 2, 0);
        dcount = 0;
        for (int i = 0; i < 3 * (MAX_WAIT + 1); i++) begin
            @(negedge ar_clk);
            if (bus.d_gnt === 1'b1) dcount++;
            tick();
        end
        checks++;
        if (dcount != 3) begin
            failures++;
            $display("FAIL contention_dgnt_count got %0d want 3", dcount);
        end
        set_p(0, 0, 0, 0);
        set_d(0, 0, 0, 0);
        tick(); tick();

        // d-only read of preloaded addr 3
        set_d(1, 0, 3, 0); tick();
        set_d(0, 0, 0, 0); tick(); tick();

        // Forced d read of addr 7, then p writes 7 next cycle, then p reads 7
        set_p(1, 0, 1, 0);
        set_d(1, 0, 7, 0);
        n = 0;
        do begin
            @(negedge ar_clk);
            dg = bus.d_gnt;
            tick();
            n++;
        end while (dg !== 1'b1 && n < 20);
        checks++;
        if (dg !== 1'b1) begin
            failures++;
            $display("FAIL forced_dgnt_timeout got %b want 1", dg);
        end
        set_d(0, 0, 0, 0);
        set_p(1, 1, 7, 32'hAA); tick();
        set_p(1, 0, 7, 0);      tick();
        set_p(0, 0, 0, 0);      tick(); tick();

        // Read granted in the same cycle reset is sampled: dropped
        set_p(1, 0, 5, 0);
        ar_rst = 1'b1;
        tick();
        set_p(0, 0, 0, 0);
        tick();
        ar_rst = 1'b0;
        tick(); tick();

        // Idle stretch
        for (int i = 0; i < 10; i++) tick();

        // Randomized traffic; each requester holds its fields until granted
        for (int i = 0; i < 2000; i++) begin
            @(negedge ar_clk);
            pg = bus.p_gnt;
            dg = bus.d_gnt;
            tick();
            if (pg || !bus.p_req) begin
                if ($urandom_range(0, 99) < 65)
                    set_p(1, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 15)), $urandom());
                else
                    set_p(0, 0, 0, 0);
            end
            if (dg || !bus.d_req) begin
                if ($urandom_range(0, 99) < 50)
                    set_d(1, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 15)), $urandom());
                else
                    set_d(0, 0, 0, 0);
            end
        end
        set_p(0, 0, 0, 0);
        set_d(0, 0, 0, 0);
        tick(); tick(); tick();
        @(negedge ar_clk);
        #1;
        checks++;
        if (pq.size() != 0 || dq.size() != 0) begin
            failures++;
            $display("FAIL pending_reads got p=%0d d=%0d want 0 0", pq.size(), dq.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
